// File: rtl/weighted_accumulator_nb_pkg.sv
// Shared state encodings and default widths for the weighted accumulator.
package weighted_accumulator_nb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int N_DEF     = 32;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/weighted_accumulator_nb_rca.sv
// n-bit ripple-carry adder; ovf_o flags signed overflow (carry into MSB != carry out).
module rca_nb #(
    parameter int n = 32
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    input  logic         cin_i,
    output logic [n-1:0] sum_o,
    output logic         ovf_o
);

    logic [n:0] c;

    always_comb begin
        c[0] = cin_i;
        for (int i = 0; i < n; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign ovf_o = c[n] ^ c[n-1];

endmodule

// File: rtl/weighted_accumulator_nb.sv
// Sequential signed accumulator of num_terms operands, each weighted by 2^in_shift.
// One term per cycle; result presented with valid/ready and held until taken.
module weighted_accumulator_nb
    import weighted_accumulator_nb_pkg::*;
#(
    parameter int n     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             in_valid,
    input  logic [n-1:0]     in_data,
    input  logic [1:0]       in_shift,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n-1:0]     SUM,
    output logic             sign_flag,
    output logic             ovf,
    output logic             busy
);

    state_e           state_q;
    logic [n-1:0]     acc_q;
    logic [CNT_W-1:0] remaining_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic [n-1:0]     operand;
    logic [n-1:0]     acc_d;
    logic             shift_ovf;
    logic             add_ovf;

    assign operand = in_data << in_shift;

    // Shifting by s loses information unless the top s+1 bits are all sign copies.
    always_comb begin
        shift_ovf = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (i <= int'(in_shift) && in_data[n-1-i] != in_data[n-1]) begin
                shift_ovf = 1'b1;
            end
        end
    end

    rca_nb #(.n(n)) u_rca (
        .a_i   (acc_q),
        .b_i   (operand),
        .cin_i (1'b0),
        .sum_o (acc_d),
        .ovf_o (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                        if (num_terms != '0) begin
                            remaining_q <= num_terms;
                            state_q     <= ACCUM;
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q       <= acc_d;
                        ovf_q       <= ovf_q | shift_ovf | add_ovf;
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign SUM       = acc_q;
    assign sign_flag = acc_q[n-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_weighted_accumulator_nb.sv
// Scoreboard bench: expected results queued at run start, popped by a monitor on each output handshake.
module tb_weighted_accumulator_nb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_terms;
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_shift;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SUM;
    logic        sign_flag;
    logic        ovf;
    logic        busy;

    typedef struct packed {
        logic [31:0] sum;
        logic        sign;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    weighted_accumulator_nb #(.n(32), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_terms (num_terms),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (SUM),
        .sign_flag (sign_flag),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Handshake completes at the next rising edge; out_ready only changes just after rising edges.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: actual SUM %0h required no output", SUM);
            end else begin
                e = exp_q.pop_front();
                chk("result_sum", SUM, e.sum);
                chk("result_sign", {31'd0, sign_flag}, {31'd0, e.sign});
                chk("result_ovf", {31'd0, ovf}, {31'd0, e.ovf});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [3:0] nt);
        start     = 1'b1;
        num_terms = nt;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] s);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout: actual in_ready 0 required 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        if (!out_valid) begin
            checks++;
            $display("FAIL result_timeout: actual out_valid 0 required 1");
        end
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sum"}, SUM, 32'd0);
        chk({tag, "_sign"}, {31'd0, sign_flag}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_terms = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        out_ready = 1'b1;
        #12;
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // 10 + 2*20 + 2*30 + 40, back-to-back
        exp_q.push_back('{32'd150, 1'b0, 1'b0});
        begin_run(4'd4);
        send(32'd10, 2'd0);
        send(32'd20, 2'd1);
        send(32'd30, 2'd1);
        send(32'd40, 2'd0);
        chk("t1_latency", {31'd0, out_valid}, 32'd1);
        wait_result();

        exp_q.push_back('{32'hFFFF_FFF9, 1'b1, 1'b0});
        begin_run(4'd2);
        send(32'd5, 2'd0);
        send(32'hFFFF_FFF4, 2'd0);
        wait_result();

        exp_q.push_back('{32'h8000_0000, 1'b1, 1'b1});
        begin_run(4'd2);
        send(32'h7FFF_FFFF, 2'd0);
        send(32'd1, 2'd0);
        wait_result();

        exp_q.push_back('{32'h8000_0000, 1'b1, 1'b1});
        begin_run(4'd1);
        send(32'h4000_0000, 2'd1);
        wait_result();

        // 4*100 - 50 + 2*7 with input gaps, start pulses and a stalled consumer
        exp_q.push_back('{32'd364, 1'b0, 1'b0});
        begin_run(4'd3);
        send(32'd100, 2'd2);
        start = 1'b1; num_terms = 4'd1;
        tick();
        start = 1'b0;
        tick(); tick();
        send(32'hFFFF_FFCE, 2'd0);
        tick(); tick(); tick();
        out_ready = 1'b0;
        send(32'd7, 2'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_sum", SUM, 32'd364);
            start = (i == 2);
            tick();
        end
        start = 1'b1; num_terms = 4'd2;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_start_ignored", {31'd0, busy}, 32'd0);
        chk("t4_idle_hold_sum", SUM, 32'd364);
        tick();

        exp_q.push_back('{32'd0, 1'b0, 1'b0});
        begin_run(4'd0);
        chk("t5_latency", {31'd0, out_valid}, 32'd1);
        tick();
        chk("t5_idle", {31'd0, busy}, 32'd0);

        begin_run(4'd4);
        send(32'd3, 2'd0);
        send(32'd9, 2'd0);
        rst = 1'b1;
        #1;
        chk_all_zero("t6_reset");
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back('{32'd15, 1'b0, 1'b0});
        begin_run(4'd2);
        send(32'd7, 2'd0);
        send(32'd8, 2'd0);
        wait_result();

        tick(); tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
